// File: rtl/draw_cmd_stack_if.sv
// Command bus between the draw-command producers/feeder and the LIFO stack.
// The master modport is the producer/feeder side; slave is the stack itself.
interface draw_cmd_stack_if #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             clear;
  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             pop;
  logic [WIDTH-1:0] top_data;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output clear, push, push_data, pop,
    input  top_data, empty, full, count, overflow, underflow
  );

  modport slave (
    input  clear, push, push_data, pop,
    output top_data, empty, full, count, overflow, underflow
  );
endinterface

// File: rtl/draw_cmd_stack.sv
// Show-ahead LIFO of draw commands feeding the feeder stage.
// Sticky overflow/underflow flags record dropped pushes and pops on empty.
module draw_cmd_stack #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  draw_cmd_stack_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_sp;
  logic             r_empty;
  logic             r_full;
  logic             r_overflow;
  logic             r_underflow;

  logic [CW-1:0]    w_spNext;
  logic             w_wrEn;
  logic [AW-1:0]    w_wrAddr;
  logic [AW-1:0]    w_topAddr;
  logic             w_setOvf;
  logic             w_setUnf;

  assign w_topAddr = AW'(r_sp - CW'(1));

  // Next pointer and write decision; push+pop on a non-empty stack replaces the top in place
  always_comb begin
    w_spNext = r_sp;
    w_wrEn   = 1'b0;
    w_wrAddr = '0;
    w_setOvf = 1'b0;
    w_setUnf = 1'b0;
    if (bus.clear) begin
      w_spNext = '0;
    end else if (bus.push && bus.pop) begin
      w_wrEn = 1'b1;
      if (r_empty) begin
        w_wrAddr = '0;
        w_spNext = CW'(1);
        w_setUnf = 1'b1;
      end else begin
        w_wrAddr = w_topAddr;
      end
    end else if (bus.push) begin
      if (r_full) begin
        w_setOvf = 1'b1;
      end else begin
        w_wrEn   = 1'b1;
        w_wrAddr = AW'(r_sp);
        w_spNext = r_sp + CW'(1);
      end
    end else if (bus.pop) begin
      if (r_empty) begin
        w_setUnf = 1'b1;
      end else begin
        w_spNext = r_sp - CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sp        <= '0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_sp    <= w_spNext;
      r_empty <= (w_spNext == '0);
      r_full  <= (w_spNext == CW'(DEPTH));
      if (w_setOvf) r_overflow  <= 1'b1;
      if (w_setUnf) r_underflow <= 1'b1;
    end
  end

  // Storage is left uninitialised on reset; entries at or above sp are never observed
  always_ff @(posedge clock) begin
    if (!reset && w_wrEn) r_mem[w_wrAddr] <= bus.push_data;
  end

  assign bus.top_data  = r_empty ? '0 : r_mem[w_topAddr];
  assign bus.empty     = r_empty;
  assign bus.full      = r_full;
  assign bus.count     = r_sp;
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
endmodule
